// File: rtl/cpu_run_controller.sv
// Load/run/dump sequencer for the pipelined cpu core's external memory ports.
// Optional CPU_RUN_CTRL_CHECKSUM_EN: XOR checksum over every dumped word.
module cpu_run_controller #(
  parameter int RUN_W = 16,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] imem_len,
  input  logic [LEN_W-1:0] dmem_len,
  input  logic [LEN_W-1:0] dump_len,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic [31:0]      dump_base,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             cpu_enable,
  output logic [31:0]      addr_ext,
  output logic [31:0]      wdata_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      addr_ext_2,
  output logic [31:0]      wdata_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum
);

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_OUT, DONE
  } state_e;

  state_e           state_q, nxt;
  logic [LEN_W-1:0] ilen_q, dlen_q, olen_q;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [RUN_W-1:0] rlen_q, cnt_q, run_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      idx_a, idxd_a, rd_a;
  logic             cap_q, rd_now, hs, idle_q, out_hs;

  function automatic state_e pick(
    input logic i_nz,
    input logic d_nz,
    input logic r_nz,
    input logic o_nz
  );
    if (i_nz)      pick = LOAD_I;
    else if (d_nz) pick = LOAD_D;
    else if (r_nz) pick = RUN;
    else if (o_nz) pick = DUMP_RD;
    else           pick = DONE;
  endfunction

  assign in_ready = (state_q == LOAD_I) || (state_q == LOAD_D);
  assign ren_ext  = 1'b0;
  assign hs       = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign idle_q   = (state_q == IDLE) || (state_q == DONE);
  assign idx_a    = {{(30-LEN_W){1'b0}}, idx_q, 2'b00};
  assign idxd_a   = {{(30-LEN_W){1'b0}}, idx_d, 2'b00};
  assign rd_a     = base_d + idxd_a;

  always_comb begin
    nxt    = state_q;
    idx_d  = idx_q;
    run_d  = rlen_q;
    base_d = base_q;
    rd_now = 1'b1;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        nxt    = pick(|imem_len, |dmem_len, |run_cycles, |dump_len);
        idx_d  = '0;
        run_d  = run_cycles;
        base_d = dump_base;
      end
      LOAD_I: if (hs) begin
        if (idx_q == ilen_q - 1'b1) begin
          idx_d = '0;
          nxt   = pick(1'b0, |dlen_q, |rlen_q, |olen_q);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LOAD_D: begin
        // final data write still owns the _2 port on DUMP_RD entry
        rd_now = 1'b0;
        if (hs) begin
          if (idx_q == dlen_q - 1'b1) begin
            idx_d = '0;
            nxt   = pick(1'b0, 1'b0, |rlen_q, |olen_q);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RUN: if (cnt_q == '0) nxt = pick(1'b0, 1'b0, 1'b0, |olen_q);
      DUMP_RD: if (ren_ext_2) nxt = DUMP_OUT;
      DUMP_OUT: if (out_hs) begin
        idx_d = idx_q + 1'b1;
        nxt   = (idx_q == olen_q - 1'b1) ? DONE : DUMP_RD;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      ilen_q      <= '0;
      dlen_q      <= '0;
      olen_q      <= '0;
      rlen_q      <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cpu_enable  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext     <= 1'b0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
    end else begin
      state_q   <= nxt;
      idx_q     <= idx_d;
      busy      <= !(nxt inside {IDLE, DONE});
      done      <= (nxt == DONE);
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      if (idle_q && start) begin
        ilen_q <= imem_len;
        dlen_q <= dmem_len;
        olen_q <= dump_len;
        rlen_q <= run_cycles;
        base_q <= dump_base;
      end
      if (hs && state_q == LOAD_I) begin
        wen_ext   <= 1'b1;
        addr_ext  <= idx_a;
        wdata_ext <= in_data;
      end
      if (hs && state_q == LOAD_D) begin
        wen_ext_2   <= 1'b1;
        addr_ext_2  <= idx_a;
        wdata_ext_2 <= in_data;
      end
      // enable trails RUN entry by a cycle so it never overlaps a load write
      if (state_q == RUN) begin
        cpu_enable <= (cnt_q != '0);
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (nxt == RUN && state_q != RUN) cnt_q <= run_d;
      if ((nxt == DUMP_RD && state_q != DUMP_RD && rd_now) ||
          (state_q == DUMP_RD && !ren_ext_2)) begin
        ren_ext_2  <= 1'b1;
        addr_ext_2 <= rd_a;
      end
      if (state_q == DUMP_RD && nxt == DUMP_OUT) cap_q <= 1'b1;
      if (cap_q) begin
        out_data  <= rdata_ext_2;
        out_valid <= 1'b1;
        cap_q     <= 1'b0;
      end
      if (out_hs) out_valid <= 1'b0;
    end
  end

`ifdef CPU_RUN_CTRL_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)               csum_q <= '0;
    else if (idle_q && start)  csum_q <= '0;
    else if (out_hs)           csum_q <= csum_q ^ out_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a 1-cycle-latency data SRAM model.
// Checksum expectations follow CPU_RUN_CTRL_CHECKSUM_EN.
module tb_cpu_run_controller;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  imem_len = '0, dmem_len = '0, dump_len = '0;
  logic [15:0] run_cycles = '0;
  logic [31:0] dump_base = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic        cpu_enable;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] rdata_ext_2 = '0;
  logic        busy, done;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  cpu_run_controller #(.RUN_W(16), .LEN_W(10)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .dump_len(dump_len),
    .run_cycles(run_cycles), .dump_base(dump_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wdata_ext(wdata_ext),
    .wen_ext(wen_ext), .ren_ext(ren_ext),
    .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2),
    .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done), .checksum(checksum)
  );

  logic        mclr = 1'b1;
  logic [31:0] mem [256];
  logic        wr_ok [256];

  // unwritten words read back as D000_0000 + word index
  always @(posedge clk) begin
    if (mclr) begin
      for (int i = 0; i < 256; i++) wr_ok[i] <= 1'b0;
    end else begin
      if (wen_ext_2) begin
        mem[addr_ext_2[9:2]]   <= wdata_ext_2;
        wr_ok[addr_ext_2[9:2]] <= 1'b1;
      end
      if (ren_ext_2)
        rdata_ext_2 <= wr_ok[addr_ext_2[9:2]] ? mem[addr_ext_2[9:2]]
                     : 32'hD000_0000 + {24'd0, addr_ext_2[9:2]};
    end
  end

  logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], rd_q[$];
  int          en_n = 0, en_rise = 0, clash = 0;
  logic        en_prev = 1'b0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (wen_ext) begin iw_a.push_back(addr_ext); iw_d.push_back(wdata_ext); end
      if (wen_ext_2) begin dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2); end
      if (ren_ext_2) rd_q.push_back(addr_ext_2);
      if (cpu_enable) en_n++;
      if (cpu_enable && !en_prev) en_rise++;
      if (cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2)) clash++;
    end
    en_prev = cpu_enable;
  end

  int npass = 0, ntot = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("push_timeout", 32'(n < 100), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pull(output logic [31:0] d, input int stall);
    int n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check("pull_timeout", 32'(n < 100), 1);
    d = out_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_data", out_data, d);
      check("hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    check("done_timeout", 32'(n < 200), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bi, bd, br, be, bx, bc;
    logic [31:0] d0, d1;
    logic [31:0] cs1, cs3, cs6;
`ifdef CPU_RUN_CTRL_CHECKSUM_EN
    cs1 = 32'h0000_0001;
    cs3 = 32'hD000_0004;
    cs6 = 32'h0F0F_0F0F;
`else
    cs1 = '0;
    cs3 = '0;
    cs6 = '0;
`endif
    repeat (3) @(negedge clk);
    mclr = 1'b0;
    check("rst_ctl", {23'd0, busy, done, cpu_enable, in_ready, out_valid,
                      wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
    check("rst_bus", addr_ext | addr_ext_2 | wdata_ext | wdata_ext_2 | out_data, 0);
    check("rst_csum", checksum, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // full sequence
    bi = iw_a.size(); bd = dw_a.size(); br = rd_q.size();
    be = en_n; bx = en_rise; bc = clash;
    imem_len = 10'd3; dmem_len = 10'd2; run_cycles = 16'd5;
    dump_base = 32'h8; dump_len = 10'd2;
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    push(32'h2001_0001);
    push(32'h2002_0002);
    push(32'h0022_1820);
    push(32'h0000_000A);
    push(32'h0000_000B);
    pull(d0, 0);
    pull(d1, 0);
    check("t1_done_lat", 32'(done), 1);
    check("t1_iw_n", 32'(iw_a.size() - bi), 3);
    check("t1_iw_a0", iw_a[bi], 32'h0);
    check("t1_iw_a1", iw_a[bi+1], 32'h4);
    check("t1_iw_a2", iw_a[bi+2], 32'h8);
    check("t1_iw_d2", iw_d[bi+2], 32'h0022_1820);
    check("t1_dw_n", 32'(dw_a.size() - bd), 2);
    check("t1_dw_a1", dw_a[bd+1], 32'h4);
    check("t1_dw_d0", dw_d[bd], 32'hA);
    check("t1_en_cyc", 32'(en_n - be), 5);
    check("t1_en_rise", 32'(en_rise - bx), 1);
    check("t1_clash", 32'(clash - bc), 0);
    check("t1_rd_n", 32'(rd_q.size() - br), 2);
    check("t1_rd_a0", rd_q[br], 32'h8);
    check("t1_rd_a1", rd_q[br+1], 32'hC);
    check("t1_out0", d0, 32'hD000_0002);
    check("t1_out1", d1, 32'hD000_0003);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_csum", checksum, cs1);

    // restart from DONE with load and dump backpressure
    bi = iw_a.size(); br = rd_q.size(); be = en_n;
    imem_len = 10'd2; dmem_len = 10'd0; run_cycles = 16'd4;
    dump_base = 32'h10; dump_len = 10'd1;
    pulse_start();
    push(32'h1111_1111);
    repeat (3) begin
      @(negedge clk);
      check("t3_gap_wen", 32'(wen_ext), 0);
    end
    push(32'h2222_2222);
    begin
      int n = 0;
      while (!cpu_enable && n < 50) begin @(negedge clk); n++; end
      check("t3_run_to", 32'(n < 50), 1);
    end
    check("t3_run_rdy", 32'(in_ready), 0);
    run_cycles = 16'd9; imem_len = 10'd7;
    pulse_start();
    run_cycles = 16'd4; imem_len = 10'd2;
    pull(d0, 4);
    check("t3_done_lat", 32'(done), 1);
    check("t3_iw_n", 32'(iw_a.size() - bi), 2);
    check("t3_iw_a1", iw_a[bi+1], 32'h4);
    check("t3_iw_d1", iw_d[bi+1], 32'h2222_2222);
    check("t3_en_cyc", 32'(en_n - be), 4);
    check("t3_rd_n", 32'(rd_q.size() - br), 1);
    check("t3_rd_a", rd_q[br], 32'h10);
    check("t3_out", d0, 32'hD000_0004);
    check("t3_csum", checksum, cs3);

    // reset during data-load word 1
    imem_len = 10'd1; dmem_len = 10'd3; run_cycles = 16'd2;
    dump_base = 32'h0; dump_len = 10'd0;
    pulse_start();
    push(32'h3333_3333);
    push(32'h4444_4444);
    in_valid = 1'b1;
    in_data  = 32'h5555_5555;
    arst_n   = 1'b0;
    #1;
    check("t4_ctl", {23'd0, busy, done, cpu_enable, in_ready, out_valid,
                     wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
    check("t4_bus", addr_ext | addr_ext_2 | wdata_ext | wdata_ext_2 | out_data, 0);
    check("t4_csum", checksum, 0);
    in_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("t4_idle", {30'd0, busy, done}, 0);

    // all counts zero
    bi = iw_a.size(); bd = dw_a.size(); br = rd_q.size(); bx = en_rise;
    imem_len = 10'd0; dmem_len = 10'd0; run_cycles = 16'd0; dump_len = 10'd0;
    pulse_start();
    check("t5_done", {30'd0, busy, done}, 32'h1);
    repeat (4) @(negedge clk);
    check("t5_no_act", 32'((iw_a.size() - bi) + (dw_a.size() - bd) +
                           (rd_q.size() - br) + (en_rise - bx)), 0);

    // data load straight into dump, checksum
    bd = dw_a.size(); br = rd_q.size(); bx = en_rise;
    imem_len = 10'd0; dmem_len = 10'd2; run_cycles = 16'd0;
    dump_base = 32'h0; dump_len = 10'd2;
    pulse_start();
    push(32'h0F0F_0000);
    push(32'h0000_0F0F);
    pull(d0, 0);
    pull(d1, 0);
    wait_done();
    check("t6_dw_n", 32'(dw_a.size() - bd), 2);
    check("t6_dw_a0", dw_a[bd], 32'h0);
    check("t6_dw_a1", dw_a[bd+1], 32'h4);
    check("t6_rd_a0", rd_q[br], 32'h0);
    check("t6_rd_a1", rd_q[br+1], 32'h4);
    check("t6_out0", d0, 32'h0F0F_0000);
    check("t6_out1", d1, 32'h0000_0F0F);
    check("t6_no_en", 32'(en_rise - bx), 0);
    check("t6_csum", checksum, cs6);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
